// File: rtl/d_mem_ctrl.sv
// d_mem_ctrl: data-memory stage for the single-cycle MIPS core.
// Models a slow synchronous data RAM with WAIT_STATES extra cycles per
// access, holds the core via stall, and pulses mem_error on illegal requests.
//
// Ports:
//   clock        system clock, rising edge
//   reset        synchronous, active-low
//   MemRead      load request
//   MemWrite     store request
//   endereco     byte address (ALU result)
//   write_data   store data (read data 2)
//   read_data    load data to write-back mux (0 unless a legal read completes)
//   stall        core holds PC/instruction while high
//   mem_error    one-cycle pulse on an illegal request
//   mem_size     (D_MEM_BYTE_EN only) 00 word, 01 half, 10 byte, 11 illegal
//   mem_unsigned (D_MEM_BYTE_EN only) zero-extend sub-word loads
//
// Optional feature macro: D_MEM_BYTE_EN (sub-word loads/stores).
//
// state  | meaning
// S_IDLE | accept a new request; N=0 accesses complete here
// S_WAIT | wait states running, request latched
// S_DONE | one cycle: read data presented or write committed
module d_mem_ctrl #(
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] endereco,
  input  logic [31:0] write_data,
`ifdef D_MEM_BYTE_EN
  input  logic [1:0]  mem_size,
  input  logic        mem_unsigned,
`endif
  output logic [31:0] read_data,
  output logic        stall,
  output logic        mem_error
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t        r_state, w_next;
  logic [3:0]    r_cnt, w_cnt_next;
  logic [AW-1:0] r_idx;
  logic [31:0]   r_data;
  logic          r_op_wr;
  logic [31:0]   r_mem [DEPTH];

  logic [AW-1:0] w_idx, w_we_idx;
  logic [31:0]   w_we_data;
  logic          w_we, w_latch;
  logic          w_req, w_both, w_misalign, w_oob, w_illegal, w_legal;

`ifdef D_MEM_BYTE_EN
  logic [1:0] r_off, r_size;
  logic       r_uns;

  function automatic logic [31:0] f_load(input logic [31:0] w, input logic [1:0] off,
                                         input logic [1:0] sz, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    case (off)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = off[1] ? w[31:16] : w[15:0];
    case (sz)
      2'b10:   f_load = uns ? {24'b0, b} : {{24{b[7]}}, b};
      2'b01:   f_load = uns ? {16'b0, h} : {{16{h[15]}}, h};
      default: f_load = w;
    endcase
  endfunction

  // Read-modify-write merge: only the addressed lanes take store data.
  function automatic logic [31:0] f_store(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [1:0] off, input logic [1:0] sz);
    f_store = old;
    case (sz)
      2'b10:
        case (off)
          2'd0:    f_store[7:0]   = wd[7:0];
          2'd1:    f_store[15:8]  = wd[7:0];
          2'd2:    f_store[23:16] = wd[7:0];
          default: f_store[31:24] = wd[7:0];
        endcase
      2'b01:
        if (off[1]) f_store[31:16] = wd[15:0];
        else        f_store[15:0]  = wd[15:0];
      default: f_store = wd;
    endcase
  endfunction

  always_comb begin
    case (mem_size)
      2'b00:   w_misalign = (endereco[1:0] != 2'b00);
      2'b01:   w_misalign = endereco[0];
      2'b10:   w_misalign = 1'b0;
      default: w_misalign = 1'b1;
    endcase
  end
`else
  assign w_misalign = (endereco[1:0] != 2'b00);
`endif

  assign w_idx     = endereco[AW+1:2];
  assign w_req     = MemRead ^ MemWrite;
  assign w_both    = MemRead & MemWrite;
  assign w_oob     = (endereco[31:2] >= 30'(DEPTH));
  assign w_illegal = (MemRead | MemWrite) & (w_both | w_misalign | w_oob);
  assign w_legal   = w_req & ~w_illegal;

  always_comb begin
    w_next     = r_state;
    w_cnt_next = r_cnt;
    w_we       = 1'b0;
    w_we_idx   = r_idx;
    w_we_data  = r_data;
    w_latch    = 1'b0;
    read_data  = 32'b0;
    stall      = 1'b0;
    mem_error  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_illegal) begin
          mem_error = 1'b1;
        end else if (w_legal) begin
          if (WAIT_STATES == 0) begin
            if (MemRead) begin
`ifdef D_MEM_BYTE_EN
              read_data = f_load(r_mem[w_idx], endereco[1:0], mem_size, mem_unsigned);
`else
              read_data = r_mem[w_idx];
`endif
            end else begin
              w_we     = 1'b1;
              w_we_idx = w_idx;
`ifdef D_MEM_BYTE_EN
              w_we_data = f_store(r_mem[w_idx], write_data, endereco[1:0], mem_size);
`else
              w_we_data = write_data;
`endif
            end
          end else begin
            stall      = 1'b1;
            w_latch    = 1'b1;
            w_cnt_next = 4'(WAIT_STATES - 1);
            // A single wait state has no WAIT cycle: the IDLE stall is it.
            w_next     = (WAIT_STATES == 1) ? S_DONE : S_WAIT;
          end
        end
      end
      S_WAIT: begin
        stall = 1'b1;
        if (!MemRead && !MemWrite) begin
          w_next     = S_IDLE;
          w_cnt_next = 4'd0;
        end else begin
          w_cnt_next = r_cnt - 4'd1;
          if (w_cnt_next == 4'd0) w_next = S_DONE;
        end
      end
      S_DONE: begin
        w_next = S_IDLE;
        if (r_op_wr) begin
          w_we = 1'b1;
`ifdef D_MEM_BYTE_EN
          w_we_data = f_store(r_mem[r_idx], r_data, r_off, r_size);
`else
          w_we_data = r_data;
`endif
        end else begin
`ifdef D_MEM_BYTE_EN
          read_data = f_load(r_mem[r_idx], r_off, r_size, r_uns);
`else
          read_data = r_mem[r_idx];
`endif
        end
      end
      default: w_next = S_IDLE;
    endcase
    // While in reset the core must not be held and nothing may be written.
    if (!reset) begin
      read_data = 32'b0;
      stall     = 1'b0;
      mem_error = 1'b0;
      w_we      = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_idx   <= '0;
      r_data  <= 32'b0;
      r_op_wr <= 1'b0;
`ifdef D_MEM_BYTE_EN
      r_off   <= 2'b0;
      r_size  <= 2'b0;
      r_uns   <= 1'b0;
`endif
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
      if (w_latch) begin
        r_idx   <= w_idx;
        r_data  <= write_data;
        r_op_wr <= MemWrite;
`ifdef D_MEM_BYTE_EN
        r_off   <= endereco[1:0];
        r_size  <= mem_size;
        r_uns   <= mem_unsigned;
`endif
      end
    end
  end

  // RAM contents survive reset.
  always_ff @(posedge clock) begin
    if (w_we) r_mem[w_we_idx] <= w_we_data;
  end

endmodule

// File: tb/tb_d_mem_ctrl.sv
module tb_d_mem_ctrl;
  localparam int DEPTH = 256;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst  [3];
  logic        mr   [3];
  logic        mw   [3];
  logic [31:0] addr [3];
  logic [31:0] wdat [3];
  logic [31:0] rdat [3];
  logic        stl  [3];
  logic        err  [3];
`ifdef D_MEM_BYTE_EN
  logic [1:0]  msz  [3];
  logic        muns [3];
`endif

  int n_assert = 0;
  int n_fail   = 0;
  logic [31:0] model [3][64];

  // Instance 0: N=2, instance 1: N=0, instance 2: N=3.
  for (genvar g = 0; g < 3; g++) begin : g_dut
    d_mem_ctrl #(.DEPTH(DEPTH), .WAIT_STATES(g == 0 ? 2 : (g == 1 ? 0 : 3))) u_dut (
      .clock(clk), .reset(rst[g]), .MemRead(mr[g]), .MemWrite(mw[g]),
      .endereco(addr[g]), .write_data(wdat[g]),
`ifdef D_MEM_BYTE_EN
      .mem_size(msz[g]), .mem_unsigned(muns[g]),
`endif
      .read_data(rdat[g]), .stall(stl[g]), .mem_error(err[g]));
  end

  function automatic int ws(int k);
    case (k)
      0:       return 2;
      1:       return 0;
      default: return 3;
    endcase
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(string tag, int k, logic [31:0] erd, logic est, logic eerr);
    chk({tag, "/read_data"}, rdat[k], erd);
    chk({tag, "/stall"}, {31'b0, stl[k]}, {31'b0, est});
    chk({tag, "/mem_error"}, {31'b0, err[k]}, {31'b0, eerr});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One instruction's worth of access; checks every cycle until it completes.
  task automatic access(int k, bit rd, bit wr, logic [31:0] a, logic [31:0] d,
                        bit scramble, logic [31:0] alt, string tag);
    bit illegal;
    int idx;
    int n;
    n = ws(k);
    mr[k] = rd; mw[k] = wr; addr[k] = a; wdat[k] = d;
    illegal = (rd && wr) || (a[1:0] != 2'b00) || (a[31:2] >= 30'(DEPTH));
    idx = int'(a[7:2]);
    if (illegal) begin
      @(negedge clk); chk_out(tag, k, 32'h0, 1'b0, 1'b1); step();
    end else if (n == 0) begin
      @(negedge clk); chk_out(tag, k, rd ? model[k][idx] : 32'h0, 1'b0, 1'b0); step();
      if (wr) model[k][idx] = d;
    end else begin
      for (int c = 0; c < n; c++) begin
        @(negedge clk); chk_out({tag, "_stall"}, k, 32'h0, 1'b1, 1'b0); step();
        if (scramble) begin addr[k] = alt; wdat[k] = ~d; end
      end
      @(negedge clk); chk_out({tag, "_done"}, k, rd ? model[k][idx] : 32'h0, 1'b0, 1'b0); step();
      if (wr) model[k][idx] = d;
    end
    mr[k] = 1'b0; mw[k] = 1'b0;
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      rst[k] = 1'b0; mr[k] = 1'b0; mw[k] = 1'b0; addr[k] = 32'h0; wdat[k] = 32'h0;
`ifdef D_MEM_BYTE_EN
      msz[k] = 2'b00; muns[k] = 1'b0;
`endif
    end
    @(negedge clk);
    for (int k = 0; k < 3; k++) chk_out("reset", k, 32'h0, 1'b0, 1'b0);
    step(); step();
    for (int k = 0; k < 3; k++) rst[k] = 1'b1;

    // Give every model word a known value.
    for (int k = 0; k < 3; k++)
      for (int w = 0; w < 64; w++)
        access(k, 1'b0, 1'b1, 32'(w * 4), $urandom, 1'b0, 32'h0, "preload");

    // N=2 store then load.
    access(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0, "n2_store");
    access(0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 32'h0, "n2_load");
    @(negedge clk); chk_out("n2_after", 0, 32'h0, 1'b0, 1'b0); step();

    // N=0 store then load back-to-back.
    access(1, 1'b0, 1'b1, 32'h20, 32'h12345678, 1'b0, 32'h0, "n0_store");
    access(1, 1'b1, 1'b0, 32'h20, 32'h0, 1'b0, 32'h0, "n0_load");

    // Illegal requests leave RAM unchanged.
    access(0, 1'b1, 1'b0, 32'h13, 32'h0, 1'b0, 32'h0, "err_misalign");
    access(0, 1'b1, 1'b0, 32'(4 * DEPTH), 32'h0, 1'b0, 32'h0, "err_oob");
    access(0, 1'b1, 1'b1, 32'h10, 32'h0BADF00D, 1'b0, 32'h0, "err_both");
    access(0, 1'b0, 1'b1, 32'h12, 32'h0BADF00D, 1'b0, 32'h0, "err_wr_misalign");
    access(0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 32'h0, "err_check");
    chk("err_model", model[0][4], 32'hDEADBEEF);

    // N=3 store cut short by reset in its second WAIT cycle.
    mw[2] = 1'b1; addr[2] = 32'h8; wdat[2] = 32'hA5A5A5A5;
    @(negedge clk); chk_out("rst_idle", 2, 32'h0, 1'b1, 1'b0); step();
    @(negedge clk); chk_out("rst_wait1", 2, 32'h0, 1'b1, 1'b0); step();
    rst[2] = 1'b0;
    @(negedge clk); chk_out("rst_held", 2, 32'h0, 1'b0, 1'b0); step();
    rst[2] = 1'b1; mw[2] = 1'b0;
    @(negedge clk); chk_out("rst_after", 2, 32'h0, 1'b0, 1'b0); step();
    access(2, 1'b1, 1'b0, 32'h8, 32'h0, 1'b0, 32'h0, "rst_load");

    // Address/data changed mid-WAIT: latched values win.
    access(0, 1'b0, 1'b1, 32'h30, 32'hCAFEF00D, 1'b1, 32'h40, "latch_store");
    access(0, 1'b1, 1'b0, 32'h40, 32'h0, 1'b0, 32'h0, "latch_other");
    access(0, 1'b1, 1'b0, 32'h30, 32'h0, 1'b0, 32'h0, "latch_target");

    // Request withdrawn in WAIT: abort without writing.
    mw[0] = 1'b1; addr[0] = 32'h14; wdat[0] = 32'h55AA55AA;
    @(negedge clk); chk_out("abort_idle", 0, 32'h0, 1'b1, 1'b0); step();
    mw[0] = 1'b0;
    @(negedge clk); chk_out("abort_wait", 0, 32'h0, 1'b1, 1'b0); step();
    @(negedge clk); chk_out("abort_after", 0, 32'h0, 1'b0, 1'b0); step();
    access(0, 1'b1, 1'b0, 32'h14, 32'h0, 1'b0, 32'h0, "abort_load");

    // Randomized traffic against the word model.
    for (int i = 0; i < 80; i++) begin
      int k, r;
      logic [31:0] a;
      k = $urandom_range(0, 2);
      r = $urandom_range(0, 9);
      a = 32'($urandom_range(0, 63) * 4);
      case (r)
        0:       access(k, 1'b1, 1'b1, a, $urandom, 1'b0, 32'h0, "rnd_both");
        1:       access(k, 1'b1, 1'b0, a | 32'($urandom_range(1, 3)), 32'h0, 1'b0, 32'h0, "rnd_mis");
        2:       access(k, 1'b0, 1'b1, 32'(4 * DEPTH) + a, $urandom, 1'b0, 32'h0, "rnd_oob");
        3, 4, 5: access(k, 1'b1, 1'b0, a, 32'h0, 1'b0, 32'h0, "rnd_rd");
        default: access(k, 1'b0, 1'b1, a, $urandom, $urandom_range(0, 1) == 1,
                        $urandom & 32'h3FC, "rnd_wr");
      endcase
      if ($urandom_range(0, 3) == 0) begin
        @(negedge clk); chk_out("rnd_idle", k, 32'h0, 1'b0, 1'b0); step();
      end
    end

`ifdef D_MEM_BYTE_EN
    mw[1] = 1'b1; addr[1] = 32'h0; wdat[1] = 32'h000080FF; msz[1] = 2'b00;
    @(negedge clk); chk_out("be_wstore", 1, 32'h0, 1'b0, 1'b0); step();
    model[1][0] = 32'h000080FF;
    mw[1] = 1'b0; mr[1] = 1'b1; msz[1] = 2'b10; muns[1] = 1'b0;
    @(negedge clk); chk_out("be_lb", 1, 32'hFFFFFFFF, 1'b0, 1'b0); step();
    addr[1] = 32'h1; muns[1] = 1'b1;
    @(negedge clk); chk_out("be_lbu", 1, 32'h00000080, 1'b0, 1'b0); step();
    mr[1] = 1'b0; mw[1] = 1'b1; addr[1] = 32'h2; wdat[1] = 32'h0000BEEF;
    msz[1] = 2'b01; muns[1] = 1'b0;
    @(negedge clk); chk_out("be_sh", 1, 32'h0, 1'b0, 1'b0); step();
    model[1][0] = 32'hBEEF80FF;
    mw[1] = 1'b0; msz[1] = 2'b00;
    access(1, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, "be_word");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: observed no completion expected finish");
    $fatal(1, "timeout");
  end

endmodule
